// File: rtl/matrix_transposer.sv
// ============================================================================
// matrix_transposer
//
// 4x4 signed matrix transposition unit for the matrix math ALU.
// A run is started by Operation == OPCODE (edge-sensitive via the armed flag).
// The source matrix arrives one row per clock on Column1..4 and is buffered.
// The transposed matrix is then streamed out one row per clock on NewRow1..4,
// with Done high while those rows are presented.
//
// Ports:
//   Clock              in   system clock, rising-edge active
//   ClearAll           in   synchronous active-low reset
//   Operation[2:0]     in   ALU operation select (OPCODE = transpose, 0 = no-op)
//   Column1..4         in   signed elements 1..4 of the current source row
//   Error              out  unsupported-operation flag (registered)
//   Done               out  high while transposed rows are presented (registered)
//   NewRow1..4         out  signed elements 1..4 of the current transposed row
// ============================================================================
module matrix_transposer #(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] OPCODE = 3'b100
) (
    input  logic                    Clock,
    input  logic                    ClearAll,
    input  logic [2:0]              Operation,
    input  logic signed [WIDTH-1:0] Column1,
    input  logic signed [WIDTH-1:0] Column2,
    input  logic signed [WIDTH-1:0] Column3,
    input  logic signed [WIDTH-1:0] Column4,
    output logic                    Error,
    output logic                    Done,
    output logic signed [WIDTH-1:0] NewRow1,
    output logic signed [WIDTH-1:0] NewRow2,
    output logic signed [WIDTH-1:0] NewRow3,
    output logic signed [WIDTH-1:0] NewRow4
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    logic                    error_q, error_d;
    logic                    done_q, done_d;

    // buf_q[r][c] holds source element A[r+1][c+1].
    logic signed [WIDTH-1:0] buf_q [4][4];
    logic signed [WIDTH-1:0] buf_d [4][4];
    logic signed [WIDTH-1:0] row_q [4];
    logic signed [WIDTH-1:0] row_d [4];
    logic signed [WIDTH-1:0] col   [4];

    assign col[0] = Column1;
    assign col[1] = Column2;
    assign col[2] = Column3;
    assign col[3] = Column4;

    always_ff @(posedge Clock) begin
        if (!ClearAll) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            armed_q <= 1'b1;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                row_q[r] <= '0;
                for (int c = 0; c < 4; c++) begin
                    buf_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            error_q <= error_d;
            done_q  <= done_d;
            row_q   <= row_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        error_d = 1'b0;
        done_d  = 1'b0;
        row_d   = row_q;
        buf_d   = buf_q;

        case (state_q)
            IDLE: begin
                if (Operation == OPCODE) begin
                    // Holding the opcode after a run does not restart it:
                    // armed is only restored by an IDLE edge without the opcode.
                    if (armed_q) begin
                        buf_d[0] = col;
                        cnt_d    = 2'd1;
                        armed_d  = 1'b0;
                        state_d  = LOAD;
                    end
                end else begin
                    armed_d = 1'b1;
                    if (Operation != 3'b000) begin
                        error_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                buf_d[cnt_q] = col;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            OUT: begin
                // Transposed row cnt+1 is source column cnt+1.
                for (int k = 0; k < 4; k++) begin
                    row_d[k] = buf_q[k][cnt_q];
                end
                done_d = 1'b1;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    assign Error   = error_q;
    assign Done    = done_q;
    assign NewRow1 = row_q[0];
    assign NewRow2 = row_q[1];
    assign NewRow3 = row_q[2];
    assign NewRow4 = row_q[3];

endmodule

// File: tb/tb_matrix_transposer.sv
// ============================================================================
// tb_matrix_transposer
//
// Self-checking bench for matrix_transposer. A transaction-level reference
// model records the source matrix of each run and predicts Error, Done and
// the transposed rows every clock. Directed scenarios are followed by
// randomized traffic.
// ============================================================================
module tb_matrix_transposer;

    localparam int         WIDTH  = 32;
    localparam logic [2:0] OPCODE = 3'b100;

    logic                    Clock;
    logic                    ClearAll;
    logic [2:0]              Operation;
    logic signed [WIDTH-1:0] Column1, Column2, Column3, Column4;
    logic                    Error, Done;
    logic signed [WIDTH-1:0] NewRow1, NewRow2, NewRow3, NewRow4;

    matrix_transposer #(.WIDTH(WIDTH), .OPCODE(OPCODE)) dut (
        .Clock    (Clock),
        .ClearAll (ClearAll),
        .Operation(Operation),
        .Column1  (Column1),
        .Column2  (Column2),
        .Column3  (Column3),
        .Column4  (Column4),
        .Error    (Error),
        .Done     (Done),
        .NewRow1  (NewRow1),
        .NewRow2  (NewRow2),
        .NewRow3  (NewRow3),
        .NewRow4  (NewRow4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase < 0 : idle; phase 1..3 : rows 2..4 still to be captured;
    // phase 4..7 : transposed row (phase-3) is emitted on this edge.
    logic signed [WIDTH-1:0] m [4][4];
    logic signed [WIDTH-1:0] exp_row [4];
    logic                    exp_err, exp_done, m_armed;
    int                      phase;

    task automatic model_edge(input logic rst_n, input logic [2:0] op,
                              input logic signed [WIDTH-1:0] c [4]);
        if (!rst_n) begin
            phase = -1; m_armed = 1'b1; exp_err = 1'b0; exp_done = 1'b0;
            for (int k = 0; k < 4; k++) exp_row[k] = '0;
        end else if (phase < 0) begin
            exp_done = 1'b0;
            exp_err  = (op != 3'b000) && (op != OPCODE);
            if (op == OPCODE) begin
                if (m_armed) begin
                    m[0] = c; phase = 1; m_armed = 1'b0;
                end
            end else begin
                m_armed = 1'b1;
            end
        end else if (phase < 4) begin
            m[phase] = c; phase++; exp_err = 1'b0; exp_done = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) exp_row[k] = m[k][phase-4];
            exp_done = 1'b1; exp_err = 1'b0;
            phase++;
            if (phase == 8) phase = -1;
        end
    endtask

    // Drive one clock with the given inputs, advance the model, and compare.
    task automatic cycle(input logic rst_n, input logic [2:0] op,
                         input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b,
                         input logic signed [WIDTH-1:0] c, input logic signed [WIDTH-1:0] d);
        logic signed [WIDTH-1:0] cv [4];
        cv[0] = a; cv[1] = b; cv[2] = c; cv[3] = d;
        ClearAll = rst_n; Operation = op;
        Column1 = a; Column2 = b; Column3 = c; Column4 = d;
        @(posedge Clock);
        model_edge(rst_n, op, cv);
        #1;
        check("Error",   {63'd0, Error}, {63'd0, exp_err});
        check("Done",    {63'd0, Done},  {63'd0, exp_done});
        check("NewRow1", {32'd0, NewRow1}, {32'd0, exp_row[0]});
        check("NewRow2", {32'd0, NewRow2}, {32'd0, exp_row[1]});
        check("NewRow3", {32'd0, NewRow3}, {32'd0, exp_row[2]});
        check("NewRow4", {32'd0, NewRow4}, {32'd0, exp_row[3]});
    endtask

    task automatic idle_cycles(input int n, input logic [2:0] op);
        for (int i = 0; i < n; i++) cycle(1'b1, op, 0, 0, 0, 0);
    endtask

    initial begin
        ClearAll = 1'b0; Operation = 3'b000;
        Column1 = '0; Column2 = '0; Column3 = '0; Column4 = '0;
        phase = -1; m_armed = 1'b1; exp_err = 1'b0; exp_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_row[k] = '0;
            for (int j = 0; j < 4; j++) m[k][j] = '0;
        end
        #2;

        // Reset held with the opcode present: no run may start.
        cycle(1'b0, OPCODE, 7, 7, 7, 7);
        cycle(1'b0, OPCODE, 7, 7, 7, 7);
        check("rst_Done", {63'd0, Done}, 64'd0);
        check("rst_Row1", {32'd0, NewRow1}, 64'd0);

        // Basic transpose with the opcode held throughout.
        cycle(1'b1, OPCODE, 1, 2, 3, 4);
        cycle(1'b1, OPCODE, 5, 6, 7, 8);
        cycle(1'b1, OPCODE, 9, 10, 11, 12);
        cycle(1'b1, OPCODE, 13, 14, 15, 16);
        cycle(1'b1, OPCODE, 0, 0, 0, 0);
        check("basic_r1e1", {32'd0, NewRow1}, 64'd1);
        check("basic_r1e2", {32'd0, NewRow2}, 64'd5);
        check("basic_r1e3", {32'd0, NewRow3}, 64'd9);
        check("basic_r1e4", {32'd0, NewRow4}, 64'd13);
        idle_cycles(3, OPCODE);
        check("basic_r4e4", {32'd0, NewRow4}, 64'd16);
        idle_cycles(4, OPCODE);      // no second run while the opcode stays
        check("basic_noRerun", {63'd0, Done}, 64'd0);

        // Constant data.
        idle_cycles(1, 3'b000);
        for (int i = 0; i < 4; i++) cycle(1'b1, OPCODE, 4, 1, 1, 1);
        cycle(1'b1, 3'b000, 0, 0, 0, 0);
        check("const_r1", {32'd0, NewRow3}, 64'd4);
        idle_cycles(4, 3'b000);

        // Signed extremes must pass through bit-exact.
        cycle(1'b1, OPCODE, -1, 32'sh8000_0000, 3, -2);
        cycle(1'b1, OPCODE, 32'sh7fff_ffff, -1, 0, 1);
        cycle(1'b1, OPCODE, 5, 6, 32'sh8000_0000, -7);
        cycle(1'b1, OPCODE, -100, 9, 8, -1);
        cycle(1'b1, OPCODE, 0, 0, 0, 0);
        check("neg_r1e1", {32'd0, NewRow1}, 64'hffff_ffff);
        cycle(1'b1, OPCODE, 0, 0, 0, 0);
        check("neg_r2e1", {32'd0, NewRow1}, 64'h8000_0000);
        idle_cycles(3, OPCODE);

        // Unsupported operation in IDLE, then back to no-op.
        cycle(1'b1, 3'b011, 0, 0, 0, 0);
        check("err_set", {63'd0, Error}, 64'd1);
        cycle(1'b1, 3'b000, 0, 0, 0, 0);
        check("err_clr", {63'd0, Error}, 64'd0);

        // Reset in the middle of the output phase, then restart.
        cycle(1'b1, OPCODE, 11, 12, 13, 14);
        cycle(1'b1, OPCODE, 21, 22, 23, 24);
        cycle(1'b1, OPCODE, 31, 32, 33, 34);
        cycle(1'b1, OPCODE, 41, 42, 43, 44);
        cycle(1'b1, OPCODE, 0, 0, 0, 0);
        cycle(1'b0, OPCODE, 0, 0, 0, 0);
        check("midrst_Row1", {32'd0, NewRow1}, 64'd0);
        cycle(1'b1, OPCODE, 2, 3, 4, 5);
        cycle(1'b1, OPCODE, 6, 7, 8, 9);
        cycle(1'b1, OPCODE, 1, 1, 1, 1);
        cycle(1'b1, OPCODE, -3, -4, -5, -6);
        idle_cycles(5, OPCODE);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            int unsigned sel;
            logic [2:0]  op;
            logic        rn;
            sel = $urandom_range(0, 9);
            if (sel < 6)      op = OPCODE;
            else if (sel < 8) op = 3'b000;
            else              op = 3'($urandom);
            rn = ($urandom_range(0, 59) != 0);
            cycle(rn, op, $urandom, $urandom, $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
